// File: rtl/anc_pkg.sv
// Shared types and defaults for the ANC sample sequencer and the filter/update blocks.
package anc_pkg;
   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_WAIT_FILTER = 2'd1,
      ST_WAIT_ERROR  = 2'd2,
      ST_WAIT_UPDATE = 2'd3
   } seq_state_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
   localparam int DEFAULT_CNT_W          = 16;

   // Width of a counter that must hold 0 .. cycles-1.
   function automatic int wait_cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction
endpackage

// File: rtl/anc_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/anc_sequencer.sv
// Per-sample sequencer: filter -> error stage -> optional LMS update, one handshake per stage,
// with a one-deep sample buffer, per-stage timeout and overrun/timeout statistics.
module anc_sequencer
   import anc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEFAULT_CNT_W
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             nc_enable_in,
   input  logic             sample_valid_in,
   output logic             filter_start_out,
   input  logic             filter_done_in,
   output logic             error_ready_out,
   input  logic             error_done_in,
   input  logic             error_locked_in,
   output logic             update_start_out,
   input  logic             update_done_in,
   output logic             nc_on_out,
   output logic             locked_out,
   output logic             busy_out,
   input  logic             clear_stats_in,
   output logic [CNT_W-1:0] overrun_count_out,
   output logic [CNT_W-1:0] timeout_count_out
);
   localparam int                WAIT_W    = wait_cnt_width(TIMEOUT_CYCLES);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t        state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              pending_reg, pending_next;
   logic              filter_start_reg, filter_start_next;
   logic              error_ready_reg, error_ready_next;
   logic              update_start_reg, update_start_next;
   logic              nc_on_reg, nc_on_next;
   logic              locked_reg, locked_next;
   logic              stage_done;
   logic              timeout_hit;
   logic [1:0]        stat_inc;
   logic [CNT_W-1:0]  stat_count [2];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_reg        <= ST_IDLE;
         wait_cnt_reg     <= '0;
         pending_reg      <= 1'b0;
         filter_start_reg <= 1'b0;
         error_ready_reg  <= 1'b0;
         update_start_reg <= 1'b0;
         nc_on_reg        <= 1'b0;
         locked_reg       <= 1'b0;
      end else begin
         state_reg        <= state_next;
         wait_cnt_reg     <= wait_cnt_next;
         pending_reg      <= pending_next;
         filter_start_reg <= filter_start_next;
         error_ready_reg  <= error_ready_next;
         update_start_reg <= update_start_next;
         nc_on_reg        <= nc_on_next;
         locked_reg       <= locked_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      stage_done = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (sample_valid_in || pending_reg) state_next = ST_WAIT_FILTER;
         end
         ST_WAIT_FILTER: begin
            stage_done = filter_done_in;
            if (filter_done_in) state_next = ST_WAIT_ERROR;
         end
         ST_WAIT_ERROR: begin
            stage_done = error_done_in;
            // Coefficients stay frozen while converged or while NC is off.
            if (error_done_in)
               state_next = (nc_on_reg && !error_locked_in) ? ST_WAIT_UPDATE : ST_IDLE;
         end
         ST_WAIT_UPDATE: begin
            stage_done = update_done_in;
            if (update_done_in) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      // A done pulse in the last allowed cycle wins over the abort.
      timeout_hit = (state_reg != ST_IDLE) && !stage_done && (wait_cnt_reg == WAIT_LAST);
      if (timeout_hit) state_next = ST_IDLE;
   end

   always_comb begin
      filter_start_next = (state_reg == ST_IDLE) && (sample_valid_in || pending_reg);
      error_ready_next  = (state_reg == ST_WAIT_FILTER) && filter_done_in;
      update_start_next = (state_reg == ST_WAIT_ERROR) && error_done_in
                          && nc_on_reg && !error_locked_in;
      nc_on_next        = (state_reg == ST_IDLE) ? nc_enable_in : nc_on_reg;
      locked_next       = ((state_reg == ST_WAIT_ERROR) && error_done_in) ? error_locked_in
                                                                          : locked_reg;
      // A strobe arriving while a buffered sample is consumed re-arms the buffer.
      if (state_reg == ST_IDLE) pending_next = sample_valid_in && pending_reg;
      else                      pending_next = pending_reg || sample_valid_in;
      if ((state_reg == ST_IDLE) || (state_next != state_reg)) wait_cnt_next = '0;
      else                                                     wait_cnt_next = wait_cnt_reg + 1'b1;
      stat_inc[0] = (state_reg != ST_IDLE) && sample_valid_in && pending_reg;
      stat_inc[1] = timeout_hit;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_stat
         sat_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .inc      (stat_inc[gi]),
            .clr      (clear_stats_in),
            .count    (stat_count[gi])
         );
      end
   endgenerate

   assign filter_start_out  = filter_start_reg;
   assign error_ready_out   = error_ready_reg;
   assign update_start_out  = update_start_reg;
   assign nc_on_out         = nc_on_reg;
   assign locked_out        = locked_reg;
   assign busy_out          = (state_reg != ST_IDLE);
   assign overrun_count_out = stat_count[0];
   assign timeout_count_out = stat_count[1];
endmodule

// File: tb/tb_anc_sequencer.sv
// Bench for anc_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_anc_sequencer;
   localparam int TMO  = 16;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic clk_in = 1'b0, rst_n_in = 1'b0;
   logic nc_enable_in = 1'b0, sample_valid_in = 1'b0, clear_stats_in = 1'b0;
   logic filter_done_in = 1'b0, error_done_in = 1'b0, error_locked_in = 1'b0, update_done_in = 1'b0;
   logic filter_start_out, error_ready_out, update_start_out, nc_on_out, locked_out, busy_out;
   logic [CW-1:0] overrun_count_out, timeout_count_out;

   int errors = 0;
   int checks = 0;
   logic [5+2*CW:0] exp_v, got_v;

   anc_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .nc_enable_in(nc_enable_in),
      .sample_valid_in(sample_valid_in), .filter_start_out(filter_start_out),
      .filter_done_in(filter_done_in), .error_ready_out(error_ready_out),
      .error_done_in(error_done_in), .error_locked_in(error_locked_in),
      .update_start_out(update_start_out), .update_done_in(update_done_in),
      .nc_on_out(nc_on_out), .locked_out(locked_out), .busy_out(busy_out),
      .clear_stats_in(clear_stats_in), .overrun_count_out(overrun_count_out),
      .timeout_count_out(timeout_count_out)
   );

   always #5 clk_in = ~clk_in;

   // Behavioural model: stage 0 = idle, 1 = filter, 2 = error, 3 = update;
   // age counts the cycles spent in the current stage, starting at 1.
   int m_stage = 0, m_age = 0, m_ovr = 0, m_tmo = 0, m_next = 0;
   bit m_pend = 0, m_nc = 0, m_lock = 0, m_fs = 0, m_er = 0, m_us = 0;
   bit m_done, m_ovr_inc, m_tmo_inc;

   always @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         m_stage = 0; m_age = 0; m_ovr = 0; m_tmo = 0; m_pend = 0;
         m_nc = 0; m_lock = 0; m_fs = 0; m_er = 0; m_us = 0;
      end else begin
         m_fs = 0; m_er = 0; m_us = 0; m_ovr_inc = 0; m_tmo_inc = 0;
         m_next = m_stage;
         if (m_stage == 0) begin
            m_nc = nc_enable_in;
            if (sample_valid_in || m_pend) begin
               m_fs = 1;
               m_next = 1;
               m_pend = sample_valid_in && m_pend;
            end
         end else begin
            m_ovr_inc = sample_valid_in && m_pend;
            m_pend = m_pend || sample_valid_in;
            m_done = (m_stage == 1 && filter_done_in) || (m_stage == 2 && error_done_in)
                     || (m_stage == 3 && update_done_in);
            if (m_done) begin
               if (m_stage == 1) begin
                  m_er = 1; m_next = 2;
               end else if (m_stage == 2) begin
                  m_lock = error_locked_in;
                  if (m_nc && !error_locked_in) begin m_us = 1; m_next = 3; end
                  else m_next = 0;
               end else m_next = 0;
            end else if (m_age >= TMO) begin
               m_next = 0; m_tmo_inc = 1;
            end
         end
         m_age = (m_next != m_stage) ? 1 : m_age + 1;
         m_stage = m_next;
         if (clear_stats_in) begin m_ovr = 0; m_tmo = 0; end
         else begin
            if (m_ovr_inc && m_ovr < CMAX) m_ovr++;
            if (m_tmo_inc && m_tmo < CMAX) m_tmo++;
         end
      end
   end

   task tick();
      @(posedge clk_in);
      #1;
   endtask

   task go_idle();
      sample_valid_in = 0; clear_stats_in = 0;
      filter_done_in = 1; error_done_in = 1; update_done_in = 1; error_locked_in = 1;
      repeat (8) tick();
      filter_done_in = 0; error_done_in = 0; update_done_in = 0; error_locked_in = 0;
      checks++;
      if (busy_out !== 1'b0) begin
         errors++; $display("FAIL go_idle_busy: got %b expected 0", busy_out);
      end
   endtask

   task clear_stats();
      clear_stats_in = 1; tick(); clear_stats_in = 0;
   endtask

   task test_reset();
      rst_n_in = 0;
      tick(); tick();
      checks++;
      got_v = {filter_start_out, error_ready_out, update_start_out, nc_on_out, locked_out,
               busy_out, overrun_count_out, timeout_count_out};
      if (got_v !== '0) begin
         errors++; $display("FAIL reset_outputs: got %b expected all zero", got_v);
      end
      rst_n_in = 1;
      tick();
      $display("reset: outputs after reset %b", got_v);
   endtask

   task test_nominal();
      go_idle(); clear_stats();
      nc_enable_in = 1; error_locked_in = 0; tick();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      checks++;
      if (filter_start_out !== 1'b1 || busy_out !== 1'b1) begin
         errors++; $display("FAIL nominal_filter_start: got fs=%b busy=%b expected 1 1", filter_start_out, busy_out);
      end
      tick();
      checks++;
      if (filter_start_out !== 1'b0) begin
         errors++; $display("FAIL nominal_fs_one_cycle: got %b expected 0", filter_start_out);
      end
      tick(); tick();
      filter_done_in = 1; tick(); filter_done_in = 0;
      checks++;
      if (error_ready_out !== 1'b1) begin
         errors++; $display("FAIL nominal_error_ready: got %b expected 1", error_ready_out);
      end
      tick(); tick(); tick();
      error_done_in = 1; tick(); error_done_in = 0;
      checks++;
      if (update_start_out !== 1'b1 || locked_out !== 1'b0) begin
         errors++; $display("FAIL nominal_update_start: got us=%b lk=%b expected 1 0", update_start_out, locked_out);
      end
      tick(); tick(); tick();
      update_done_in = 1; tick(); update_done_in = 0;
      checks++;
      if (busy_out !== 1'b0 || overrun_count_out !== '0 || timeout_count_out !== '0) begin
         errors++; $display("FAIL nominal_end: got busy=%b ovr=%0d tmo=%0d expected 0 0 0", busy_out, overrun_count_out, timeout_count_out);
      end
      $display("nominal: sequence complete busy=%b", busy_out);
   endtask

   task test_locked_skip();
      go_idle();
      nc_enable_in = 1; tick();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      filter_done_in = 1; tick(); filter_done_in = 0;
      error_locked_in = 1; error_done_in = 1; tick(); error_done_in = 0; error_locked_in = 0;
      checks++;
      if (update_start_out !== 1'b0 || locked_out !== 1'b1 || busy_out !== 1'b0) begin
         errors++; $display("FAIL locked_skip: got us=%b lk=%b busy=%b expected 0 1 0", update_start_out, locked_out, busy_out);
      end
      $display("locked_skip: locked=%b busy=%b", locked_out, busy_out);
   endtask

   task test_buffer_overrun();
      go_idle(); clear_stats();
      nc_enable_in = 1; tick();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      tick();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      checks++;
      if (overrun_count_out !== 2'd1) begin
         errors++; $display("FAIL overrun_count: got %0d expected 1", overrun_count_out);
      end
      filter_done_in = 1; tick(); filter_done_in = 0;
      error_locked_in = 1; error_done_in = 1; tick(); error_done_in = 0;
      checks++;
      if (busy_out !== 1'b0 || filter_start_out !== 1'b0) begin
         errors++; $display("FAIL buffered_gap: got busy=%b fs=%b expected 0 0", busy_out, filter_start_out);
      end
      tick();
      checks++;
      if (filter_start_out !== 1'b1) begin
         errors++; $display("FAIL buffered_start: got %b expected 1", filter_start_out);
      end
      filter_done_in = 1; tick(); filter_done_in = 0;
      error_done_in = 1; tick(); error_done_in = 0; error_locked_in = 0;
      checks++;
      if (busy_out !== 1'b0 || overrun_count_out !== 2'd1) begin
         errors++; $display("FAIL buffered_end: got busy=%b ovr=%0d expected 0 1", busy_out, overrun_count_out);
      end
      $display("buffer_overrun: overruns=%0d", overrun_count_out);
   endtask

   task test_timeout();
      go_idle(); clear_stats();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      repeat (TMO - 1) tick();
      checks++;
      if (busy_out !== 1'b1) begin
         errors++; $display("FAIL timeout_early: got busy=%b expected 1", busy_out);
      end
      tick();
      checks++;
      if (busy_out !== 1'b0 || timeout_count_out !== 2'd1) begin
         errors++; $display("FAIL timeout_abort: got busy=%b tmo=%0d expected 0 1", busy_out, timeout_count_out);
      end
      filter_done_in = 1; tick(); filter_done_in = 0;
      checks++;
      if (error_ready_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++; $display("FAIL late_done_ignored: got er=%b busy=%b expected 0 0", error_ready_out, busy_out);
      end
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      repeat (TMO - 1) tick();
      filter_done_in = 1; tick(); filter_done_in = 0;
      checks++;
      if (error_ready_out !== 1'b1 || busy_out !== 1'b1 || timeout_count_out !== 2'd1) begin
         errors++; $display("FAIL done_wins_boundary: got er=%b busy=%b tmo=%0d expected 1 1 1", error_ready_out, busy_out, timeout_count_out);
      end
      error_locked_in = 1; error_done_in = 1; tick(); error_done_in = 0; error_locked_in = 0;
      $display("timeout: timeouts=%0d", timeout_count_out);
   endtask

   task test_nc_toggle();
      go_idle();
      nc_enable_in = 0; tick();
      sample_valid_in = 1; tick(); sample_valid_in = 0;
      nc_enable_in = 1; tick(); tick();
      checks++;
      if (nc_on_out !== 1'b0) begin
         errors++; $display("FAIL nc_hold_mid: got %b expected 0", nc_on_out);
      end
      filter_done_in = 1; tick(); filter_done_in = 0;
      error_locked_in = 0; error_done_in = 1; tick(); error_done_in = 0;
      checks++;
      if (update_start_out !== 1'b0 || busy_out !== 1'b0 || nc_on_out !== 1'b0) begin
         errors++; $display("FAIL nc_off_no_update: got us=%b busy=%b nc=%b expected 0 0 0", update_start_out, busy_out, nc_on_out);
      end
      tick();
      checks++;
      if (nc_on_out !== 1'b1) begin
         errors++; $display("FAIL nc_update_idle: got %b expected 1", nc_on_out);
      end
      $display("nc_toggle: nc_on=%b", nc_on_out);
   endtask

   task test_reset_mid();
      go_idle(); clear_stats();
      nc_enable_in = 1; tick();
      sample_valid_in = 1; tick();
      tick(); tick(); sample_valid_in = 0;
      filter_done_in = 1; tick(); filter_done_in = 0;
      error_locked_in = 0; error_done_in = 1; tick(); error_done_in = 0;
      checks++;
      if (update_start_out !== 1'b1 || overrun_count_out !== 2'd1) begin
         errors++; $display("FAIL reset_mid_setup: got us=%b ovr=%0d expected 1 1", update_start_out, overrun_count_out);
      end
      rst_n_in = 0; #1;
      checks++;
      got_v = {filter_start_out, error_ready_out, update_start_out, nc_on_out, locked_out,
               busy_out, overrun_count_out, timeout_count_out};
      if (got_v !== '0) begin
         errors++; $display("FAIL reset_mid_async: got %b expected all zero", got_v);
      end
      tick(); tick();
      rst_n_in = 1; tick();
      $display("reset_mid: outputs after async reset %b", got_v);
   endtask

   task test_saturation();
      go_idle(); clear_stats();
      sample_valid_in = 1; tick();
      repeat (6) tick();
      sample_valid_in = 0;
      checks++;
      if (overrun_count_out !== 2'd3) begin
         errors++; $display("FAIL overrun_saturate: got %0d expected 3", overrun_count_out);
      end
      sample_valid_in = 1; clear_stats_in = 1; tick(); sample_valid_in = 0; clear_stats_in = 0;
      checks++;
      if (overrun_count_out !== 2'd0) begin
         errors++; $display("FAIL clear_priority: got %0d expected 0", overrun_count_out);
      end
      go_idle();
      $display("saturation: overruns after clear=%0d", overrun_count_out);
   endtask

   task test_random();
      go_idle();
      for (int cyc = 0; cyc < 700; cyc++) begin
         sample_valid_in = ($urandom_range(0, 4) == 0);
         filter_done_in  = ($urandom_range(0, 3) == 0);
         error_done_in   = ($urandom_range(0, 3) == 0);
         update_done_in  = ($urandom_range(0, 3) == 0);
         error_locked_in = ($urandom_range(0, 2) == 0);
         clear_stats_in  = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 15) == 0) nc_enable_in = !nc_enable_in;
         tick();
         exp_v = {m_fs, m_er, m_us, m_nc, m_lock, (m_stage != 0), CW'(m_ovr), CW'(m_tmo)};
         got_v = {filter_start_out, error_ready_out, update_start_out, nc_on_out, locked_out,
                  busy_out, overrun_count_out, timeout_count_out};
         checks++;
         if (got_v !== exp_v) begin
            errors++; $display("FAIL random_cycle_%0d: got %b expected %b", cyc, got_v, exp_v);
         end
         if (filter_start_out === 1'b1)
            $display("random: cycle %0d sequence start nc_on=%b", cyc, nc_on_out);
      end
      sample_valid_in = 0; filter_done_in = 0; error_done_in = 0; update_done_in = 0;
      error_locked_in = 0; clear_stats_in = 0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_locked_skip();
      test_buffer_overrun();
      test_timeout();
      test_nc_toggle();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/anc_sequencer.md
# anc_sequencer

Per-sample sequencer for the noise-cancellation datapath. On each audio sample strobe it starts the anti-noise filter, then the `error_calculator` stage (via `error_ready`), then an optional LMS coefficient update, with one handshake per stage. It owns the `nc_on` control seen by the error stage, buffers one early sample, and counts overruns and stalled stages. It sits between the audio sample clock-enable domain logic and the filter, error and update blocks.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum cycles to wait for any stage's done pulse.
- `CNT_W`, default 16: width of the saturating statistics counters.

- `clk_in`  in  1  system clock; all logic on the rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `nc_enable_in`  in  1  user noise-cancel enable; level signal.
- `sample_valid_in`  in  1  one-cycle strobe per new audio sample.
- `filter_start_out`  out  1  one-cycle pulse that starts the filter.
- `filter_done_in`  in  1  one-cycle pulse: filter output ready.
- `error_ready_out`  out  1  one-cycle pulse that starts the error stage.
- `error_done_in`  in  1  one-cycle pulse: error stage done.
- `error_locked_in`  in  1  error stage converged flag; level signal.
- `update_start_out`  out  1  one-cycle pulse that starts the LMS update.
- `update_done_in`  in  1  one-cycle pulse: coefficients written.
- `nc_on_out`  out  1  noise-cancel active, as seen by the error stage.
- `locked_out`  out  1  `error_locked_in` captured at the last `error_done_in`.
- `busy_out`  out  1  high when state ≠ IDLE.
- `clear_stats_in`  in  1  synchronous clear of both counters.
- `overrun_count_out`  out  CNT_W  dropped samples; saturates.
- `timeout_count_out`  out  CNT_W  aborted sequences; saturates.

## Operation
- States: IDLE, WAIT_FILTER, WAIT_ERROR, WAIT_UPDATE.
- **IDLE**
  - If `sample_valid_in` or `pending` is set: pulse `filter_start_out`, clear `pending`, go to WAIT_FILTER.
  - `nc_on_out` <= `nc_enable_in`. This is the only state where `nc_on_out` may change, so a sequence always sees a constant `nc_on`.
- **WAIT_FILTER**
  - On `filter_done_in`: pulse `error_ready_out`, go to WAIT_ERROR.
- **WAIT_ERROR**
  - On `error_done_in`: `locked_out` <= `error_locked_in`.
  - If `nc_on_out && !error_locked_in`: pulse `update_start_out`, go to WAIT_UPDATE.
  - Otherwise go to IDLE; coefficients stay frozen while locked or while NC is off.
- **WAIT_UPDATE**
  - On `update_done_in`: go to IDLE.
- **Sample buffering**
  - `sample_valid_in` while state ≠ IDLE sets `pending`.
  - If `pending` is already set, the sample is dropped and `overrun_count_out` increments.
- **Stage timeout**
  - A wait counter clears on entry to each wait state.
  - If it reaches `TIMEOUT_CYCLES`-1 without the expected done pulse, go to IDLE and increment `timeout_count_out`.
  - `pending` is preserved across a timeout.
- **Stray pulses:** done pulses that arrive outside their matching wait state are ignored.
- **Counters:** saturate at all-ones. `clear_stats_in` has priority over an increment in the same cycle.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `pending` 0, all pulses 0, `nc_on_out` 0, `locked_out` 0, counters 0.
- Latency, event at cycle t:
  - `sample_valid_in` at t (in IDLE) → `filter_start_out` at t+1.
  - `filter_done_in` at t → `error_ready_out` at t+1.
  - `error_done_in` at t → `update_start_out` at t+1.
- Back-to-back operation:
  - A terminal done at t with `pending` set → `filter_start_out` at t+2 (IDLE occupies t+1).
  - `sample_valid_in` in the same cycle as a terminal done sets `pending`; no overrun.
- Timeout: abort at the `TIMEOUT_CYCLES`-th cycle after entering the wait state.
  - A done pulse arriving in that same cycle wins, and no timeout is counted.
- Reset mid-sequence: asynchronous return to reset values, with no output pulse.

## Structure
- Package `anc_pkg`:
  - `seq_state_t` enum.
  - Default `TIMEOUT_CYCLES` and `CNT_W` constants.
  - Shared with the filter and update blocks.
- Sub-module `sat_counter` (width parameter, `inc`, `clr`, saturating), instantiated twice.
- The FSM, wait counter and `pending` flag live in `anc_sequencer` itself.

## Test plan
- **Nominal sequence.** `nc_enable_in`=1, `error_locked_in`=0, each done returned 3 cycles after its start → start pulses at t+1, t+5, t+9; back to IDLE after `update_done_in`; counters 0.
- **Locked skip.** `error_locked_in`=1 at `error_done_in` → no `update_start_out`; `locked_out`=1; IDLE the next cycle.
- **Buffering and overrun.** Three `sample_valid_in` strobes during one sequence → one buffered sample runs, starting 2 cycles after the terminal done; `overrun_count_out`=1.
- **Timeout.** `TIMEOUT_CYCLES`=16, `filter_done_in` never arrives → IDLE 16 cycles after entering WAIT_FILTER; `timeout_count_out`=1; a late `filter_done_in` is ignored.
- **NC toggle mid-sequence.** `nc_enable_in` changes during WAIT_FILTER → `nc_on_out` changes only after the sequence returns to IDLE.
- **Reset and saturation.** `rst_n_in` low in WAIT_UPDATE → all outputs 0 immediately. With `CNT_W`=2, 5 overruns → count 3; `clear_stats_in` → 0.
